// File: rtl/key_shift_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_shift_loader_pkg
// Description : Shared locking constants. Holds the frame FSM state encoding
//               and the default key width / serial timeout used by the
//               key-handling blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package key_shift_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t c_st_idle  = 2'd0;
  localparam state_t c_st_shift = 2'd1;
  localparam state_t c_st_check = 2'd2;

  localparam int c_key_w_def   = 8;
  localparam int c_timeout_def = 16;

endpackage
`default_nettype wire

// File: rtl/key_shift_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : key_shift_loader_if
// Description : Serial key-load bus between a key source (master) and the
//               key shift loader (slave), including the committed key output.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_shift_loader_if
  import key_shift_loader_pkg::*;
#(
  parameter int KEY_W = c_key_w_def
);
  logic             load_start;
  logic             sdata;
  logic             svalid;
  logic             sready;
  logic             key_clear;
  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             busy;
  logic             err;

  modport master (
    output load_start, sdata, svalid, key_clear,
    input  sready, key, key_valid, busy, err
  );

  modport slave (
    input  load_start, sdata, svalid, key_clear,
    output sready, key, key_valid, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/key_shift_loader_frame_counter.sv
`default_nettype none
// ============================================================================
// Module      : key_frame_counter
// Description : Bit counter and inter-bit idle counter for one key frame.
//               Flags the last key bit and the idle-limit expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module key_frame_counter
  import key_shift_loader_pkg::*;
#(
  parameter int KEY_W   = c_key_w_def,
  parameter int TIMEOUT = c_timeout_def
) (
  input  wire  clk,
  input  wire  rst,
  input  logic clear,     // start of a new frame
  input  logic bit_inc,   // a serial bit was accepted on this edge
  input  logic tick,      // frame active, no bit accepted on this edge
  output logic last_bit,  // next accepted bit in SHIFT is the KEY_W-th
  output logic expire     // next idle edge reaches the timeout limit
);
  localparam int c_cnt_w = $clog2(KEY_W + 1);

  logic [c_cnt_w-1:0] r_bitcnt;
  logic [7:0]         r_tcnt;

  // Count accepted bits; idle counter restarts on every accepted bit.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt <= '0;
      r_tcnt   <= '0;
    end else if (clear) begin
      r_bitcnt <= '0;
      r_tcnt   <= '0;
    end else if (bit_inc) begin
      r_bitcnt <= r_bitcnt + 1'b1;
      r_tcnt   <= '0;
    end else if (tick) begin
      r_tcnt   <= r_tcnt + 1'b1;
    end
  end

  assign last_bit = (r_bitcnt == c_cnt_w'(KEY_W - 1));
  assign expire   = (r_tcnt == 8'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/key_shift_loader.sv
`default_nettype none
// ============================================================================
// Module      : key_shift_loader
// Description : Receives a serial key frame (KEY_W bits LSB-first plus an
//               even-parity bit) and commits it atomically to the key output
//               of a locked FSM. Parity failure or idle timeout pulses err.
//               All state changes on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module key_shift_loader
  import key_shift_loader_pkg::*;
#(
  parameter int KEY_W   = c_key_w_def,
  parameter int TIMEOUT = c_timeout_def
) (
  input  wire               clk,
  input  wire               rst,
  key_shift_loader_if.slave bus
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic [KEY_W-1:0] r_shadow;
  logic [KEY_W-1:0] w_shadow_shifted;
  logic [KEY_W-1:0] r_key;
  logic             r_key_valid;
  logic             r_err;

  logic w_active;
  logic w_accept;
  logic w_start;
  logic w_shift_bit;
  logic w_commit;
  logic w_fail;
  logic w_parity_ok;
  logic w_last_bit;
  logic w_expire;

  assign w_accept    = bus.svalid & w_active;
  assign w_parity_ok = (bus.sdata == ^r_shadow);

  // New bits enter at the MSB so the first bit ends up at bit 0.
  generate
    if (KEY_W == 1) begin : g_shift_one
      assign w_shadow_shifted = bus.sdata;
    end else begin : g_shift_multi
      assign w_shadow_shifted = {bus.sdata, r_shadow[KEY_W-1:1]};
    end
  endgenerate

  key_frame_counter #(
    .KEY_W   (KEY_W),
    .TIMEOUT (TIMEOUT)
  ) u_frame_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_start),
    .bit_inc  (w_accept),
    .tick     (w_active & ~w_accept),
    .last_bit (w_last_bit),
    .expire   (w_expire)
  );

  // State register.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; key_clear aborts any frame.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.key_clear) begin
      w_state_nxt = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle:  if (bus.load_start) w_state_nxt = c_st_shift;
        c_st_shift: begin
          if (w_accept && w_last_bit)     w_state_nxt = c_st_check;
          else if (!w_accept && w_expire) w_state_nxt = c_st_idle;
        end
        c_st_check: if (w_accept || w_expire) w_state_nxt = c_st_idle;
        default:    w_state_nxt = c_st_idle;
      endcase
    end
  end

  // Frame-control strobes decoded from the current state.
  always_comb begin
    w_active    = (r_state == c_st_shift) || (r_state == c_st_check);
    w_start     = !bus.key_clear && (r_state == c_st_idle) && bus.load_start;
    w_shift_bit = !bus.key_clear && (r_state == c_st_shift) && w_accept;
    w_commit    = !bus.key_clear && (r_state == c_st_check) && w_accept && w_parity_ok;
    w_fail      = !bus.key_clear &&
                  ((((r_state == c_st_check) && w_accept && !w_parity_ok)) ||
                   (w_active && !w_accept && w_expire));
  end

  // Shadow shift, atomic key commit/clear and one-cycle error pulse.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_shadow    <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_fail;
      if (w_start)          r_shadow <= '0;
      else if (w_shift_bit) r_shadow <= w_shadow_shifted;
      if (bus.key_clear) begin
        r_key       <= '0;
        r_key_valid <= 1'b0;
      end else if (w_commit) begin
        r_key       <= r_shadow;
        r_key_valid <= 1'b1;
      end
    end
  end

  assign bus.sready    = w_active;
  assign bus.busy      = w_active;
  assign bus.key       = r_key;
  assign bus.key_valid = r_key_valid;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_key_shift_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_shift_loader
// Description : Self-checking bench for key_shift_loader with a frame-level
//               reference model (bit queue, idle count, parity by popcount).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_shift_loader;
  localparam int KEY_W   = 8;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  key_shift_loader_if #(.KEY_W(KEY_W)) bus ();

  key_shift_loader #(
    .KEY_W   (KEY_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  bit               m_active;
  bit               m_q[$];
  int               m_idle;
  logic [KEY_W-1:0] m_key;
  logic             m_kv;
  logic             m_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [KEY_W-1:0] q_value();
    logic [KEY_W-1:0] v;
    v = '0;
    for (int i = 0; i < m_q.size(); i++) if (m_q[i]) v = v + (KEY_W'(1) << i);
    return v;
  endfunction

  task automatic model_reset();
    m_active = 0; m_q.delete(); m_idle = 0;
    m_key = '0; m_kv = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit ls, input bit sd, input bit sv, input bit kc);
    logic [KEY_W-1:0] v;
    m_err = 0;
    if (kc) begin
      m_key = '0; m_kv = 0; m_active = 0;
    end else if (!m_active) begin
      if (ls) begin m_active = 1; m_q.delete(); m_idle = 0; end
    end else if (sv) begin
      m_idle = 0;
      if (m_q.size() < KEY_W) begin
        m_q.push_back(sd);
      end else begin
        v = q_value();
        if ((($countones(v) + int'(sd)) % 2) == 0) begin m_key = v; m_kv = 1; end
        else m_err = 1;
        m_active = 0;
      end
    end else begin
      m_idle++;
      if (m_idle >= TIMEOUT) begin m_err = 1; m_active = 0; end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".key"},    32'(bus.key),       32'(m_key));
    chk({tag, ".kv"},     32'(bus.key_valid), 32'(m_kv));
    chk({tag, ".err"},    32'(bus.err),       32'(m_err));
    chk({tag, ".sready"}, 32'(bus.sready),    32'(m_active));
    chk({tag, ".busy"},   32'(bus.busy),      32'(m_active));
  endtask

  // Drive one set of inputs across one falling edge, then compare.
  task automatic cycle(input bit ls, input bit sd, input bit sv, input bit kc);
    bus.load_start = ls; bus.sdata = sd; bus.svalid = sv; bus.key_clear = kc;
    @(negedge clk);
    model_edge(ls, sd, sv, kc);
    #1;
    check_outputs("cyc");
  endtask

  task automatic send_frame(input logic [KEY_W-1:0] k, input bit bad,
                            input int gmin, input int gmax, input bit noise);
    bit b;
    int g;
    cycle(1, 0, 0, 0);
    for (int i = 0; i <= KEY_W; i++) begin
      g = $urandom_range(gmax, gmin);
      for (int j = 0; j < g; j++) cycle(noise && ($urandom_range(0, 3) == 0), 1'($urandom), 0, 0);
      b = (i < KEY_W) ? k[i] : ((^k) ^ bad);
      cycle(0, b, 1, 0);
    end
    cycle(0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rst");
    rst = 1'b0;
  endtask

  initial begin
    logic [KEY_W-1:0] k;
    n_checks = 0; n_errors = 0;
    rst = 1'b1;
    bus.load_start = 0; bus.sdata = 0; bus.svalid = 0; bus.key_clear = 0;
    model_reset();
    #2;
    check_outputs("reset");
    @(negedge clk); #2;
    rst = 1'b0;

    // Known frame 0x4D with correct parity
    send_frame(8'h4D, 0, 0, 0, 0);
    chk("good_key", 32'(bus.key), 32'h4D);
    chk("good_kv",  32'(bus.key_valid), 32'd1);

    // Same frame with wrong parity: key kept
    send_frame(8'h4D, 1, 0, 0, 0);
    chk("badpar_key", 32'(bus.key), 32'h4D);

    // Timeout after 3 bits
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0); cycle(0, 0, 1, 0); cycle(0, 1, 1, 0);
    for (int j = 0; j < TIMEOUT - 1; j++) cycle(0, 0, 0, 0);
    chk("pre_timeout_busy", 32'(bus.busy), 32'd1);
    cycle(0, 0, 0, 0);
    chk("timeout_err",  32'(bus.err),  32'd1);
    chk("timeout_busy", 32'(bus.busy), 32'd0);
    chk("timeout_key",  32'(bus.key),  32'h4D);
    cycle(0, 0, 0, 0);

    // Gaps of TIMEOUT-1 between bits must not time out
    send_frame(8'hC3, 0, TIMEOUT - 1, TIMEOUT - 1, 0);
    chk("maxgap_key", 32'(bus.key), 32'hC3);

    // key_clear on the parity edge wins over commit
    k = 8'h3C;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < KEY_W; i++) cycle(0, k[i], 1, 0);
    cycle(0, ^k, 1, 1);
    chk("clr_key", 32'(bus.key), 32'h0);
    chk("clr_kv",  32'(bus.key_valid), 32'd0);
    chk("clr_err", 32'(bus.err), 32'd0);

    // Reset mid-frame then a clean frame
    send_frame(8'h11, 0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0);
    pulse_reset();
    cycle(0, 1, 1, 0);
    send_frame(8'hA5, 0, 0, 0, 0);
    chk("after_rst_key", 32'(bus.key), 32'hA5);

    // Ignored load_start mid-frame and svalid toggles in IDLE
    for (int j = 0; j < 4; j++) cycle(0, 1'($urandom), 1'(j), 0);
    send_frame(8'h5A, 0, 1, 3, 1);
    chk("noise_key", 32'(bus.key), 32'h5A);

    // Random well-formed frames, some with bad parity or long gaps
    for (int f = 0; f < 30; f++) begin
      k = KEY_W'($urandom);
      send_frame(k, ($urandom_range(0, 3) == 0), 0,
                 ($urandom_range(0, 4) == 0) ? TIMEOUT + 1 : 3, 1);
    end

    // Unstructured random traffic
    for (int c = 0; c < 800; c++) begin
      cycle($urandom_range(0, 7) == 0, 1'($urandom),
            (c < 500) ? 1'($urandom) : ($urandom_range(0, 19) == 0),
            $urandom_range(0, 59) == 0);
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_shift_loader.md
KEY_SHIFT_LOADER -- requirements
Module: key_shift_loader

Interface
REQ-001 Parameter KEY_W, default 8: number of key bits delivered to a locked FSM benchmark; legal range 1..32.
REQ-002 Parameter TIMEOUT, default 16: idle-cycle limit between serial bits; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on the falling edge, matching the benchmark FSMs.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load_start  input  1  one-cycle request to begin a key frame.
REQ-006 sdata  input  1  serial key/parity bit.
REQ-007 svalid  input  1  sdata qualifier.
REQ-008 sready  output  1  loader accepts sdata this cycle.
REQ-009 key_clear  input  1  zeroise the committed key.
REQ-010 key  output  KEY_W  committed key, drives keyinput* of the locked FSM.
REQ-011 key_valid  output  1  key holds a parity-checked frame.
REQ-012 busy  output  1  frame in progress.
REQ-013 err  output  1  one-cycle pulse on parity failure or timeout.

Function
REQ-014 FSM states are IDLE, SHIFT and CHECK; every other encoding returns to IDLE on the next edge.
REQ-015 IDLE: sready=0 and busy=0; load_start=1 moves to SHIFT and clears the shadow register, bit counter and timeout counter.
REQ-016 SHIFT: sready=1 and busy=1; each svalid&sready edge shifts sdata into the shadow register LSB-first, increments the bit counter and clears the timeout counter.
REQ-017 SHIFT: after the KEY_W-th accepted bit, the state moves to CHECK.
REQ-018 CHECK: sready=1 and busy=1; the next accepted bit is the even-parity bit over the KEY_W shadow bits.
REQ-019 Parity correct: key<=shadow and key_valid<=1 on the same edge; return to IDLE.
REQ-020 Parity wrong: err pulses for one cycle, key and key_valid are unchanged, return to IDLE.
REQ-021 In SHIFT or CHECK, the timeout counter increments on each edge without an accepted bit; reaching TIMEOUT pulses err, leaves key unchanged and returns to IDLE.
REQ-022 load_start while busy is ignored.
REQ-023 key_clear=1 in any state forces key=0 and key_valid=0 on the next edge and aborts any frame to IDLE without err.
REQ-024 key_clear has priority over commit in the same cycle.
REQ-025 svalid while sready=0 is dropped.
REQ-026 Latency is KEY_W+1 accepted bits from load_start to key update, minimum KEY_W+2 edges.
REQ-027 key never shows a partial frame; it changes only on commit or clear.

Reset
REQ-028 rst=1 immediately forces IDLE, key=0, key_valid=0, err=0, sready=0, busy=0, and zeroes all counters and the shadow register.
REQ-029 rst asserted mid-frame discards the frame with no err pulse.

Structure
REQ-030 The state encoding constants (IDLE, SHIFT, CHECK) and the default KEY_W and TIMEOUT values belong in a shared locking package reused by the other key-handling blocks.
REQ-031 The bit counter and timeout counter form one natural sub-module, key_frame_counter; everything else stays flat.

Verification
REQ-032 KEY_W=8, load_start, then bits 1,0,1,1,0,0,1,0 (LSB first) and parity 0 -> key=8'h4D, key_valid=1, err never asserted.
REQ-033 Same frame with parity 1 -> err pulses for exactly one cycle, and key and key_valid keep their prior values.
REQ-034 load_start, 3 bits, then svalid=0 for 16 edges -> err pulses, state returns to IDLE, key unchanged.
REQ-035 key_clear asserted on the edge the parity bit is accepted -> key=0 and key_valid=0, no err.
REQ-036 rst pulse after 5 bits, then a full valid frame with key 8'hA5 -> key=8'hA5; no residue from the aborted frame.
REQ-037 load_start pulsed mid-frame and svalid toggled in IDLE -> frame result unaffected and sready stays 0 in IDLE.
